// File: rtl/grid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grid_pkg
//  Description : Shared constants and types for the grid coordinate tracker
//                and its move-command feeder.
//  Revision    : 1.0  initial release
// ============================================================================
package grid_pkg;

    // Direction encodings shared with the tracker
    localparam logic [1:0] DIR_XPOS = 2'b00;
    localparam logic [1:0] DIR_XNEG = 2'b01;
    localparam logic [1:0] DIR_YPOS = 2'b10;
    localparam logic [1:0] DIR_YNEG = 2'b11;

    // Largest move the tracker can absorb in a single clock
    localparam int MAX_STEP = 3;

    // Largest grid coordinate
    localparam int GRID_MAX = 15;

    // Default command length width
    localparam int CMD_LEN_W = 4;

    // Packed move command {dir, len}
    typedef struct packed {
        logic [1:0]           dir;
        logic [CMD_LEN_W-1:0] len;
    } move_cmd_t;

    // Sequencer state: ISSUE while a command still has steps outstanding
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } seq_state_t;

endpackage : grid_pkg
`default_nettype wire

// File: rtl/move_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : move_cmd_fifo
//  Description : Synchronous FIFO with occupancy count. Flush empties it and
//                wins over a push or pop at the same edge. Head entry is
//                presented combinationally from registered storage.
//  Revision    : 1.0  initial release
// ============================================================================
module move_cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int                 c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]      c_depth = (c_aw+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic              w_push;
    logic              w_pop;

    // Accept only operations that are legal for the current occupancy
    assign w_push  = push && (r_count != c_depth) && !flush;
    assign w_pop   = pop  && (r_count != '0)      && !flush;

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign empty   = (r_count == '0);

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and count update; pointers wrap naturally at power-of-2 depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : move_cmd_fifo
`default_nettype wire

// File: rtl/move_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : move_cmd_sequencer
//  Description : Buffers coarse move commands and slices each one into
//                per-clock chunks of at most MAX_STEP steps for the grid
//                coordinate tracker. All tracker-facing outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module move_cmd_sequencer
    import grid_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_dir,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    flush,
    output logic [1:0]              dir,
    output logic [1:0]              steps,
    output logic                    step_valid,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int                     c_cnt_w    = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0]     c_depth    = c_cnt_w'(DEPTH);
    localparam logic [LEN_W-1:0]       c_max_step = LEN_W'(MAX_STEP);
    localparam int                     c_data_w   = 2 + LEN_W;

    logic [LEN_W-1:0]    r_rem;
    logic [1:0]          r_dir;
    logic [1:0]          r_steps;
    logic                r_step_valid;

    logic [LEN_W-1:0]    w_rem_nxt;
    logic [1:0]          w_dir_nxt;
    logic [1:0]          w_steps_nxt;
    logic                w_step_valid_nxt;

    logic                w_push;
    logic                w_pop;
    logic [c_data_w-1:0] w_head;
    logic [1:0]          w_head_dir;
    logic [LEN_W-1:0]    w_head_len;
    logic                w_fifo_empty;
    logic [c_cnt_w-1:0]  w_count;
    logic [LEN_W-1:0]    w_src;
    logic [LEN_W-1:0]    w_chunk;
    seq_state_t          w_state;

    // Ready depends only on occupancy, never on cmd_valid
    assign cmd_ready  = rst_n && (w_count < c_depth);
    assign w_push     = cmd_valid && cmd_ready && !flush;

    assign w_head_dir = w_head[LEN_W +: 2];
    assign w_head_len = w_head[LEN_W-1:0];

    move_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (c_data_w)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (flush),
        .wr_data ({cmd_dir, cmd_len}),
        .rd_data (w_head),
        .count   (w_count),
        .empty   (w_fifo_empty)
    );

    // State is implied by whether steps remain; the chunk source follows it
    assign w_state = (r_rem != '0) ? ST_ISSUE : ST_IDLE;
    assign w_src   = (w_state == ST_ISSUE) ? r_rem : w_head_len;
    assign w_chunk = (w_src > c_max_step) ? c_max_step : w_src;

    // Next-state logic: flush first, then continue a command or load a new one
    always_comb begin
        w_rem_nxt        = r_rem;
        w_dir_nxt        = r_dir;
        w_steps_nxt      = 2'd0;
        w_step_valid_nxt = 1'b0;
        w_pop            = 1'b0;
        if (flush) begin
            w_rem_nxt = '0;
        end else begin
            case (w_state)
                ST_ISSUE: begin
                    w_steps_nxt      = w_chunk[1:0];
                    w_rem_nxt        = r_rem - w_chunk;
                    w_step_valid_nxt = 1'b1;
                end
                default: begin
                    if (!w_fifo_empty) begin
                        w_pop            = 1'b1;
                        w_dir_nxt        = w_head_dir;
                        w_steps_nxt      = w_chunk[1:0];
                        w_rem_nxt        = w_head_len - w_chunk;
                        w_step_valid_nxt = (w_head_len != '0);
                    end
                end
            endcase
        end
    end

    // Remaining-step counter and registered tracker outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem        <= '0;
            r_dir        <= DIR_XPOS;
            r_steps      <= 2'd0;
            r_step_valid <= 1'b0;
        end else begin
            r_rem        <= w_rem_nxt;
            r_dir        <= w_dir_nxt;
            r_steps      <= w_steps_nxt;
            r_step_valid <= w_step_valid_nxt;
        end
    end

    assign dir        = r_dir;
    assign steps      = r_steps;
    assign step_valid = r_step_valid;
    assign fifo_count = w_count;
    assign busy       = r_step_valid || (r_rem != '0) || (w_count != '0);

endmodule : move_cmd_sequencer
`default_nettype wire
